cic_decimator: RTL and testbench
================================

// Module: cic_decimator
// PURPOSE
//  Multi-stage CIC decimation filter: STAGES cascaded integrators at input rate, decimation by a
//  runtime-selectable rate, STAGES comb stages (differential delay 1) at output rate, then truncation.
//  Sits between the mixer/NCO output and the FIR compensation stage; one instance per I/Q rail.
// PARAMETERS
//  IN_WIDTH   16   signed input sample width
//  STAGES     5    number of integrator and comb stages (>=1)
//  R_MAX      64   largest decimation rate accepted
//  ACC_WIDTH  46   internal width; must be >= IN_WIDTH + STAGES*ceil(log2(R_MAX))
//  OUT_WIDTH  24   output width (<= ACC_WIDTH); top OUT_WIDTH bits of the comb output
//  RATE_WIDTH 7    width of rate port; must hold R_MAX
// PORTS
//  clock      in   1          single clock; all logic on posedge
//  reset_n    in   1          synchronous, active-low reset
//  in_strobe  in   1          qualifies in_data; may be high every cycle
//  in_data    in   IN_WIDTH   signed input sample
//  rate       in   RATE_WIDTH requested decimation rate
//  out_strobe out  1          one-cycle pulse: out_data updated
//  out_data   out  OUT_WIDTH  signed decimated sample, held between strobes
// BEHAVIOUR
//  Reset (reset_n low at a posedge): integrators, comb delays, comb pipeline, valid pipe, phase counter,
//   out_data <= 0, out_strobe <= 0; active rate <= clamp(rate). In-flight samples dropped. Mid-run
//   reset takes effect on that edge; nothing emitted until a full new decimation period.
//  clamp(r): r<2 -> 2; r>R_MAX -> R_MAX; else r.
//  Integrators (only on in_strobe, all updated on the same edge; two's-complement wrap intended):
//   int[0] <= int[0] + sext(in_data); int[k] <= int[k] + int[k-1] (pre-update value), k>=1.
//  Phase counter: counts in_strobe 0..R-1. Tick cycle T = cycle with in_strobe high and count==R-1;
//   on that edge count <= 0 and R <= clamp(rate). Rate changes only take effect at a tick boundary.
//  Decimation pipeline: end of T+1 sample <= int[STAGES-1]; comb k registered at end of T+2+k:
//   c[k] <= x_k - d[k]; d[k] <= x_k (x_0 = sample, x_k = c[k-1]); valid bit shifts with data.
//  Output: out_data <= c[STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH] (truncate, no rounding) and
//   out_strobe high for exactly the one cycle T+STAGES+2; otherwise out_strobe low.
//  Back-to-back ticks (R=2, in_strobe every cycle) must not drop or merge outputs: pipeline is fully
//   valid-tagged, no stalls, no backpressure.
//  in_strobe low: no state change except decimation/comb pipeline draining.
//  Gain = R^STAGES; not normalised for R<R_MAX (downstream compensates).
// TESTING  (bench config IN_WIDTH=8 STAGES=3 R_MAX=4 ACC_WIDTH=14 OUT_WIDTH=14 RATE_WIDTH=3)
//  Impulse: reset, rate=4, in_data=1 on first strobe then 0, strobe every cycle -> out_data 3,12,1,0,0..
//  DC: in_data=1 constant, rate=4 -> out_data transient then settles to 64 from 4th output onward.
//  Latency: tick at cycle T -> out_strobe high only in cycle T+5; exactly one pulse per 4 strobes.
//  Wrap: in_data=-128 constant, rate=4 -> settles to -8192 (14-bit min), no corruption.
//  Rate change: rate 4->2 mid-period -> change applied at next tick; then one pulse per 2 strobes,
//   DC=1 settles to 8; rate=0 or 7 -> behaves as 2 or 4 respectively.
//  Reset mid-run: reset_n low one cycle during pipeline fill -> out_strobe low, out_data 0, impulse
//   test then repeats exactly.

Source files
------------

// File: rtl/cic_decimator.sv
// ============================================================================
//  Module   : cic_decimator
//  Purpose  : STAGES-order CIC decimator. Integrators run at the input rate,
//             decimation by a runtime-selectable rate (clamped to 2..R_MAX),
//             STAGES comb sections (differential delay 1) at the output rate,
//             and truncation to the top OUT_WIDTH bits of the last comb.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_decimator #(
  parameter int IN_WIDTH   = 16,
  parameter int STAGES     = 5,
  parameter int R_MAX      = 64,
  parameter int ACC_WIDTH  = 46,
  parameter int OUT_WIDTH  = 24,
  parameter int RATE_WIDTH = 7
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_strobe,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic        [RATE_WIDTH-1:0] rate,
  output logic                         out_strobe,
  output logic signed [OUT_WIDTH-1:0]  out_data
);

  localparam logic [RATE_WIDTH-1:0] C_RATE_MIN = RATE_WIDTH'(2);
  localparam logic [RATE_WIDTH-1:0] C_RATE_MAX = RATE_WIDTH'(R_MAX);
  localparam logic [RATE_WIDTH-1:0] C_ONE      = RATE_WIDTH'(1);

  logic        [RATE_WIDTH-1:0] w_rate_clamped;
  logic        [RATE_WIDTH-1:0] r_rate;
  logic        [RATE_WIDTH-1:0] r_phase;
  logic                         w_tick;
  logic                         r_tick_d;
  logic signed [ACC_WIDTH-1:0]  w_in_ext;
  logic signed [ACC_WIDTH-1:0]  r_integ [STAGES];
  logic signed [ACC_WIDTH-1:0]  r_sample;
  logic                         r_sample_vld;
  logic signed [ACC_WIDTH-1:0]  w_stage_in  [STAGES];
  logic                         w_stage_vld [STAGES];
  logic signed [OUT_WIDTH-1:0]  r_out_data;
  logic                         r_out_strobe;

  // Requested rate limited to the range the accumulator width was sized for
  always_comb begin
    w_rate_clamped = rate;
    if (rate < C_RATE_MIN) begin
      w_rate_clamped = C_RATE_MIN;
    end else if (rate > C_RATE_MAX) begin
      w_rate_clamped = C_RATE_MAX;
    end
  end

  assign w_in_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign w_tick   = in_strobe && (r_phase == (r_rate - C_ONE));

  // Phase counter; the active rate is only reloaded on a decimation tick
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_phase <= '0;
      r_rate  <= w_rate_clamped;
    end else if (in_strobe) begin
      if (w_tick) begin
        r_phase <= '0;
        r_rate  <= w_rate_clamped;
      end else begin
        r_phase <= r_phase + C_ONE;
      end
    end
  end

  // Integrator cascade: every stage adds the previous stage's pre-update value
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_integ[k] <= '0;
      end
    end else if (in_strobe) begin
      r_integ[0] <= r_integ[0] + w_in_ext;
      for (int k = 1; k < STAGES; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  // Decimation register: captures the last integrator the cycle after a tick
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tick_d     <= 1'b0;
      r_sample     <= '0;
      r_sample_vld <= 1'b0;
    end else begin
      r_tick_d     <= w_tick;
      r_sample_vld <= r_tick_d;
      if (r_tick_d) begin
        r_sample <= r_integ[STAGES-1];
      end
    end
  end

  assign w_stage_in[0]  = r_sample;
  assign w_stage_vld[0] = r_sample_vld;

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic signed [ACC_WIDTH-1:0] r_delay;
    logic signed [ACC_WIDTH-1:0] w_diff;

    assign w_diff = w_stage_in[k] - r_delay;

    // Comb delay element advances only when a valid decimated sample passes
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_delay <= '0;
      end else if (w_stage_vld[k]) begin
        r_delay <= w_stage_in[k];
      end
    end

    if (k < STAGES-1) begin : g_mid
      logic signed [ACC_WIDTH-1:0] r_comb;
      logic                        r_vld;

      // Intermediate comb output register, valid bit travels with the data
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_comb <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_vld <= w_stage_vld[k];
          if (w_stage_vld[k]) begin
            r_comb <= w_diff;
          end
        end
      end

      assign w_stage_in[k+1]  = r_comb;
      assign w_stage_vld[k+1] = r_vld;
    end else begin : g_last
      // Final comb writes straight into the truncated, held output register
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_out_data   <= '0;
          r_out_strobe <= 1'b0;
        end else begin
          r_out_strobe <= w_stage_vld[k];
          if (w_stage_vld[k]) begin
            r_out_data <= w_diff[ACC_WIDTH-1 -: OUT_WIDTH];
          end
        end
      end

      if (OUT_WIDTH < ACC_WIDTH) begin : g_trunc
        // Discarded LSBs of the truncation, intentionally left unused
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^w_diff[ACC_WIDTH-OUT_WIDTH-1:0];
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_strobe = r_out_strobe;

endmodule

`default_nettype wire

// File: tb/tb_cic_decimator.sv
// ============================================================================
//  Module   : tb_cic_decimator
//  Purpose  : Self-checking bench for cic_decimator (3 stages, R_MAX 4,
//             14-bit accumulator). A sample-level model pushes each expected
//             output with its due cycle; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_decimator;

  localparam int IN_WIDTH   = 8;
  localparam int STAGES     = 3;
  localparam int R_MAX      = 4;
  localparam int ACC_WIDTH  = 14;
  localparam int OUT_WIDTH  = 14;
  localparam int RATE_WIDTH = 3;
  localparam int LATENCY    = STAGES + 2;

  logic                         clock = 1'b0;
  logic                         reset_n = 1'b0;
  logic                         in_strobe = 1'b0;
  logic signed [IN_WIDTH-1:0]   in_data = '0;
  logic        [RATE_WIDTH-1:0] rate = 3'd4;
  logic                         out_strobe;
  logic signed [OUT_WIDTH-1:0]  out_data;

  cic_decimator #(
    .IN_WIDTH  (IN_WIDTH),
    .STAGES    (STAGES),
    .R_MAX     (R_MAX),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .RATE_WIDTH(RATE_WIDTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_strobe (in_strobe),
    .in_data   (in_data),
    .rate      (rate),
    .out_strobe(out_strobe),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic signed [ACC_WIDTH-1:0] value;
    int                          due;
  } exp_t;

  exp_t                        sb[$];
  logic signed [OUT_WIDTH-1:0] obs[$];
  logic signed [OUT_WIDTH-1:0] last_out = '0;

  logic signed [ACC_WIDTH-1:0] m_int [STAGES];
  logic signed [ACC_WIDTH-1:0] m_d   [STAGES];
  int                          m_cnt;
  int                          m_rate;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int clampr(input int r);
    if (r < 2) return 2;
    if (r > R_MAX) return R_MAX;
    return r;
  endfunction

  // Reference: integrate one sample; on a tick, run the combs and queue the result
  task automatic model_step(input logic signed [IN_WIDTH-1:0] d);
    logic signed [ACC_WIDTH-1:0] x;
    logic signed [ACC_WIDTH-1:0] y;
    bit tick;
    tick = (m_cnt == m_rate - 1);
    for (int k = STAGES - 1; k >= 1; k--) m_int[k] = m_int[k] + m_int[k-1];
    m_int[0] = m_int[0] + ACC_WIDTH'(d);
    if (tick) begin
      x = m_int[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        y = x - m_d[k];
        m_d[k] = x;
        x = y;
      end
      sb.push_back('{value: x, due: cyc + LATENCY});
      m_cnt  = 0;
      m_rate = clampr(int'(rate));
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive(input bit stb, input logic signed [IN_WIDTH-1:0] d);
    in_strobe = stb;
    in_data   = d;
    if (stb) model_step(d);
    @(posedge clock);
    #1;
    in_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, IN_WIDTH'($urandom));
  endtask

  task automatic do_reset();
    in_strobe = 1'b0;
    reset_n   = 1'b0;
    sb.delete();
    for (int k = 0; k < STAGES; k++) begin
      m_int[k] = '0;
      m_d[k]   = '0;
    end
    m_cnt  = 0;
    m_rate = clampr(int'(rate));
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    last_out = '0;
    obs.delete();
    check("reset_out_strobe", out_strobe, 0);
    check("reset_out_data", out_data, 0);
  endtask

  // Monitor: compare every pulse with the scoreboard, check holding and missed pulses
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (out_strobe) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.value);
          check("strobe_cycle", cyc, e.due);
        end
        obs.push_back(out_data);
        last_out = out_data;
      end else begin
        check("hold_out_data", out_data, last_out);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          check("missed_strobe", cyc, sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic run_impulse(input string tag);
    int imp_exp[5] = '{3, 12, 1, 0, 0};
    drive(1'b1, 8'sd1);
    for (int i = 1; i < 20; i++) drive(1'b1, 8'sd0);
    idle(LATENCY + 3);
    check({tag, "_count"}, obs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs.size()) check({tag, "_value"}, obs[i], imp_exp[i]);
    end
  endtask

  typedef struct {
    string                       name;
    logic [RATE_WIDTH-1:0]       rate0;
    logic [RATE_WIDTH-1:0]       rate1;
    int                          switch_at;
    logic signed [IN_WIDTH-1:0]  din;
    bit                          gaps;
    int                          n_strobes;
    logic signed [OUT_WIDTH-1:0] settle;
    int                          n_out;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t_tick;
    vecs[0] = '{"dc_r4",      3'd4, 3'd4, -1,  8'sd1,    1'b0, 40, 14'sd64,    10};
    vecs[1] = '{"dc_r2",      3'd2, 3'd2, -1,  8'sd1,    1'b0, 40, 14'sd8,     20};
    vecs[2] = '{"dc_r0",      3'd0, 3'd0, -1,  8'sd1,    1'b0, 40, 14'sd8,     20};
    vecs[3] = '{"dc_r7",      3'd7, 3'd7, -1,  8'sd1,    1'b0, 40, 14'sd64,    10};
    vecs[4] = '{"wrap_neg",   3'd4, 3'd4, -1, -8'sd128,  1'b0, 40, -14'sd8192, 10};
    vecs[5] = '{"dc_r3_gaps", 3'd3, 3'd3, -1,  8'sd2,    1'b1, 42, 14'sd54,    14};
    vecs[6] = '{"rate_4to2",  3'd4, 3'd2,  6,  8'sd1,    1'b0, 40, 14'sd8,     18};
    vecs[7] = '{"dc_r4_gaps", 3'd4, 3'd4, -1,  8'sd5,    1'b1, 40, 14'sd320,   10};

    repeat (2) @(posedge clock);
    #1;

    // Impulse response
    rate = 3'd4;
    do_reset();
    run_impulse("impulse");

    // Latency: the tick cycle is followed by exactly one pulse LATENCY cycles later
    rate = 3'd4;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'sd1);
    t_tick = cyc;
    drive(1'b1, 8'sd1);
    for (int j = 1; j <= LATENCY + 1; j++) begin
      check("latency_pulse", out_strobe, (cyc == t_tick + LATENCY) ? 1 : 0);
      @(posedge clock);
      #1;
    end
    idle(2);

    // Table-driven DC / wrap / rate-clamp / rate-change runs
    foreach (vecs[v]) begin
      rate = vecs[v].rate0;
      do_reset();
      for (int i = 0; i < vecs[v].n_strobes; i++) begin
        if (i == vecs[v].switch_at) rate = vecs[v].rate1;
        if (vecs[v].gaps && $urandom_range(0, 2) == 0) drive(1'b0, IN_WIDTH'($urandom));
        drive(1'b1, vecs[v].din);
      end
      idle(LATENCY + 3);
      check({vecs[v].name, "_count"}, obs.size(), vecs[v].n_out);
      check({vecs[v].name, "_drained"}, sb.size(), 0);
      check({vecs[v].name, "_settle"}, out_data, vecs[v].settle);
    end

    // Reset while the pipeline is filling, then the impulse must repeat exactly
    rate = 3'd4;
    do_reset();
    drive(1'b1, 8'sd1);
    for (int i = 1; i < 6; i++) drive(1'b1, 8'sd0);
    do_reset();
    idle(LATENCY + 2);
    check("midreset_no_output", obs.size(), 0);
    run_impulse("impulse_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
